// File: rtl/frame_display_reader_pkg.sv
// frame_display_reader_pkg
// Shared constants and types for the display-side frame reader.
// The image dimensions are the same ones the image processor uses when it
// writes the processed frame, so both ends agree on the memory layout.
// Optional build macro used by the reader: FRAME_PIXEL_DOUBLE_EN.

package frame_display_reader_pkg;

    // Memory word layout is {R[3:0], G[3:0], B[3:0]}
    localparam int DATA_WIDTH = 12;
    localparam int ADDR_WIDTH = 19;

    // Processed image size, shared with the image processor
    localparam int IMG_W = 400;
    localparam int IMG_H = 300;

    // 800x600@60 Hz timing on a 40 MHz pixel clock
    localparam int H_ACT  = 800;
    localparam int H_FP   = 40;
    localparam int H_SYNC = 128;
    localparam int H_BP   = 88;
    localparam int V_ACT  = 600;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 4;
    localparam int V_BP   = 23;

    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

    // Counters are wide enough for both totals (1056 and 628)
    localparam int CNT_W = 12;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SCAN = 2'd2
    } state_t;

    // True when val lies in the half-open span [lo, lo+len)
    function automatic logic in_span(input cnt_t val, input int lo, input int len);
        return (val >= cnt_t'(lo)) && (val < cnt_t'(lo + len));
    endfunction

endpackage

// File: rtl/frame_display_reader_if.sv
// frame_display_reader_if
// Groups the processed-image memory read port and the VGA pin bundle.
// master: the frame reader (drives address and pixels).
// slave:  the memory/monitor side (returns read data, consumes pixels).

interface frame_display_reader_if #(
    parameter int DATA_WIDTH = frame_display_reader_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = frame_display_reader_pkg::ADDR_WIDTH
);
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [3:0]            vga_r;
    logic [3:0]            vga_g;
    logic [3:0]            vga_b;
    logic                  hsync;
    logic                  vsync;
    logic                  de;

    modport master (
        output r_addr,
        input  r_data,
        output vga_r,
        output vga_g,
        output vga_b,
        output hsync,
        output vsync,
        output de
    );

    modport slave (
        input  r_addr,
        output r_data,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  hsync,
        input  vsync,
        input  de
    );
endinterface

// File: rtl/frame_display_reader_vga_timing_gen.sv
// vga_timing_gen
// Free-running horizontal/vertical counters with undelayed sync, display
// enable and line/frame boundary strobes. Also exposes the counter values
// for the next clock so the reader can fetch one position ahead.

module vga_timing_gen #(
    parameter int H_ACT  = frame_display_reader_pkg::H_ACT,
    parameter int H_FP   = frame_display_reader_pkg::H_FP,
    parameter int H_SYNC = frame_display_reader_pkg::H_SYNC,
    parameter int H_BP   = frame_display_reader_pkg::H_BP,
    parameter int V_ACT  = frame_display_reader_pkg::V_ACT,
    parameter int V_FP   = frame_display_reader_pkg::V_FP,
    parameter int V_SYNC = frame_display_reader_pkg::V_SYNC,
    parameter int V_BP   = frame_display_reader_pkg::V_BP
) (
    input  logic                            clk_p,
    input  logic                            rst,
    output frame_display_reader_pkg::cnt_t  h_cnt,
    output frame_display_reader_pkg::cnt_t  v_cnt,
    output frame_display_reader_pkg::cnt_t  h_nxt,
    output frame_display_reader_pkg::cnt_t  v_nxt,
    output logic                            active,
    output logic                            hsync_raw,
    output logic                            vsync_raw,
    output logic                            line_end,
    output logic                            frame_end
);
    import frame_display_reader_pkg::*;

    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    // Boundary strobes and the counter values for the following clock
    always_comb begin
        line_end  = (h_cnt == cnt_t'(H_TOT - 1));
        frame_end = line_end && (v_cnt == cnt_t'(V_TOT - 1));
        h_nxt     = line_end ? '0 : h_cnt + cnt_t'(1);
        v_nxt     = v_cnt;
        if (line_end) begin
            v_nxt = (v_cnt == cnt_t'(V_TOT - 1)) ? '0 : v_cnt + cnt_t'(1);
        end
    end

    // Region decode on the current position (not yet pipelined)
    always_comb begin
        active    = (h_cnt < cnt_t'(H_ACT)) && (v_cnt < cnt_t'(V_ACT));
        hsync_raw = in_span(h_cnt, H_ACT + H_FP, H_SYNC);
        vsync_raw = in_span(v_cnt, V_ACT + V_FP, V_SYNC);
    end

    // Counters run in every reader state so the monitor never loses lock
    always_ff @(posedge clk_p or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

endmodule

// File: rtl/frame_display_reader.sv
// frame_display_reader
// Scans the processed image out of memory once the processor flags it ready
// and drives a VGA pixel stream. The address register is loaded with the
// address for the position the counters reach on the next clock, so with the
// one-clock memory and the colour register a pixel reaches the pins two
// clocks after its counter position, aligned with the delayed sync/de.
// Build option: define FRAME_PIXEL_DOUBLE_EN to show each image pixel as a
// 2x2 block filling the whole active area; otherwise the image sits 1:1 at
// the top-left and the rest of the active area is black.

module frame_display_reader #(
    parameter int DATA_WIDTH = frame_display_reader_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = frame_display_reader_pkg::ADDR_WIDTH,
    parameter int IMG_W      = frame_display_reader_pkg::IMG_W,
    parameter int IMG_H      = frame_display_reader_pkg::IMG_H,
    parameter int H_ACT      = frame_display_reader_pkg::H_ACT,
    parameter int H_FP       = frame_display_reader_pkg::H_FP,
    parameter int H_SYNC     = frame_display_reader_pkg::H_SYNC,
    parameter int H_BP       = frame_display_reader_pkg::H_BP,
    parameter int V_ACT      = frame_display_reader_pkg::V_ACT,
    parameter int V_FP       = frame_display_reader_pkg::V_FP,
    parameter int V_SYNC     = frame_display_reader_pkg::V_SYNC,
    parameter int V_BP       = frame_display_reader_pkg::V_BP
) (
    input  logic                        clk_p,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        frame_done,
    frame_display_reader_if.master      bus
);
    import frame_display_reader_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(IMG_W);

    cnt_t   h_cnt, v_cnt, h_nxt, v_nxt;
    logic   active, hsync_raw, vsync_raw, line_end, frame_end;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] col, row_base, col_nxt, row_nxt, r_addr_q;
    logic                  win_nxt, fetch_nxt;
    logic                  pix_q1, pix_q2;
    logic [DATA_WIDTH-1:0] pix_q;
    logic                  de_q1, hs_q1, vs_q1;
    logic                  de_q2, hs_q2, vs_q2;
    logic                  last_q1;

    vga_timing_gen #(
        .H_ACT  (H_ACT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_ACT  (V_ACT),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk_p     (clk_p),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .h_nxt     (h_nxt),
        .v_nxt     (v_nxt),
        .active    (active),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .line_end  (line_end),
        .frame_end (frame_end)
    );

    // State register
    always_ff @(posedge clk_p or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: arm on start, scan from a frame boundary, re-check start only at frame end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                if (!start) begin
                    state_nxt = IDLE;
                end else if (frame_end) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (frame_end && !start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == SCAN);

    // Incremental column/row-base for the next position; no multiplier needed
    always_comb begin
        col_nxt = col;
        row_nxt = row_base;
        win_nxt = 1'b0;
`ifdef FRAME_PIXEL_DOUBLE_EN
        if (frame_end) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (line_end) begin
            col_nxt = '0;
            if (v_cnt[0] && (v_cnt < cnt_t'(2 * IMG_H - 1))) begin
                row_nxt = row_base + ROW_STEP;
            end
        end else if (h_cnt[0] && (h_cnt < cnt_t'(2 * IMG_W - 1))) begin
            col_nxt = col + ADDR_WIDTH'(1);
        end
        win_nxt = (h_nxt < cnt_t'(2 * IMG_W)) && (v_nxt < cnt_t'(2 * IMG_H));
`else
        if (frame_end) begin
            col_nxt = '0;
            row_nxt = '0;
        end else if (line_end) begin
            col_nxt = '0;
            if (v_cnt < cnt_t'(IMG_H - 1)) begin
                row_nxt = row_base + ROW_STEP;
            end
        end else if (h_cnt < cnt_t'(IMG_W - 1)) begin
            col_nxt = col + ADDR_WIDTH'(1);
        end
        win_nxt = (h_nxt < cnt_t'(IMG_W)) && (v_nxt < cnt_t'(IMG_H));
`endif
        fetch_nxt = win_nxt && (state_nxt == SCAN);
    end

    // Column/row-base track the counters; r_addr only moves inside the scanned window
    always_ff @(posedge clk_p or negedge rst) begin
        if (!rst) begin
            col      <= '0;
            row_base <= '0;
            r_addr_q <= '0;
            pix_q1   <= 1'b0;
            pix_q2   <= 1'b0;
        end else begin
            col      <= col_nxt;
            row_base <= row_nxt;
            if (fetch_nxt) begin
                r_addr_q <= row_nxt + col_nxt;
            end
            pix_q1   <= fetch_nxt;
            pix_q2   <= pix_q1;
        end
    end

    // Colour register: memory word for fetched positions, black everywhere else
    always_ff @(posedge clk_p or negedge rst) begin
        if (!rst) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_q2 ? bus.r_data : '0;
        end
    end

    // Two-stage delay on sync/de and the last-pixel strobe to line up with the colour path
    always_ff @(posedge clk_p or negedge rst) begin
        if (!rst) begin
            de_q1      <= 1'b0;
            hs_q1      <= 1'b0;
            vs_q1      <= 1'b0;
            de_q2      <= 1'b0;
            hs_q2      <= 1'b0;
            vs_q2      <= 1'b0;
            last_q1    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            de_q1      <= active;
            hs_q1      <= hsync_raw;
            vs_q1      <= vsync_raw;
            de_q2      <= de_q1;
            hs_q2      <= hs_q1;
            vs_q2      <= vs_q1;
            last_q1    <= (state == SCAN) && (h_cnt == cnt_t'(H_ACT - 1))
                          && (v_cnt == cnt_t'(V_ACT - 1));
            frame_done <= last_q1;
        end
    end

    assign bus.r_addr = r_addr_q;
    assign bus.vga_r  = pix_q[11:8];
    assign bus.vga_g  = pix_q[7:4];
    assign bus.vga_b  = pix_q[3:0];
    assign bus.hsync  = hs_q2;
    assign bus.vsync  = vs_q2;
    assign bus.de     = de_q2;

endmodule
